// File: rtl/apple_kbd_ctrl.sv
// Apple II keyboard front end: turns a polled keycode into strobed presses with
// auto-repeat, buffers them in a small FIFO and serves them to the 6502 at $C000/$C010.
module apple_kbd_ctrl #(
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 3333333
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  keycode,
  input  logic [15:0] bus_addr,
  input  logic        bus_access,
  output logic        kbd_sel,
  output logic [7:0]  kbd_data,
  output logic        key_strobe,
  output logic [4:0]  fifo_count,
  output logic        overflow
);

  localparam int AW      = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DELAY_TC  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_TC = CW'(REPEAT_PERIOD - 1);
  localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [6:0]      prev_code_reg;
  logic [6:0]      code;
  logic            push;

  logic [6:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg, count_next;
  logic [6:0]      latch_reg;
  logic            strobe_reg;
  logic            overflow_reg;
  logic            clear, pop, push_ok;

  assign code = keycode[6:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      prev_code_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      prev_code_reg <= code;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    push       = 1'b0;
    if (code == 7'd0) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (code != prev_code_reg) begin
      push       = 1'b1;
      cnt_next   = '0;
      state_next = DELAY;
    end else begin
      unique case (state_reg)
        DELAY: begin
          if (cnt_reg == DELAY_TC) begin
            push       = 1'b1;
            cnt_next   = '0;
            state_next = REPEAT;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        REPEAT: begin
          if (cnt_reg == PERIOD_TC) begin
            push     = 1'b1;
            cnt_next = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A clear blocks the pop in the same cycle so the strobe is seen low for at least one cycle.
  assign clear   = bus_access && (bus_addr[15:4] == 12'hC01);
  assign pop     = !strobe_reg && (count_reg != '0) && !clear;
  assign push_ok = push && ((count_reg != DEPTH_L) || pop);

  always_comb begin
    unique case ({push_ok, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= code;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      latch_reg    <= '0;
      strobe_reg   <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (push && !push_ok) overflow_reg <= 1'b1;
      if (clear) begin
        strobe_reg <= 1'b0;
      end else if (pop) begin
        strobe_reg <= 1'b1;
        latch_reg  <= fifo_mem[rd_ptr_reg];
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  assign kbd_sel    = (bus_addr[15:4] == 12'hC00);
  assign kbd_data   = {strobe_reg, latch_reg};
  assign key_strobe = strobe_reg;
  assign fifo_count = 5'(count_reg);
  assign overflow   = overflow_reg;

endmodule

// File: doc/apple_kbd_ctrl.md
APPLE_KBD_CTRL -- requirements
Module: apple_kbd_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, keypress queue depth (power of 2, 2..16).
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000, clk cycles a key is held before the first auto-repeat (min 2).
REQ-003 SHALL have parameter REPEAT_PERIOD, default 3333333, clk cycles between subsequent auto-repeats (min 2).
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 keycode  in  8  key code from the keycode PIO out_port; bits [6:0] = 7-bit ASCII, [6:0]==0 means no key; bit 7 ignored.
REQ-007 bus_addr  in  16  6502 bus address.
REQ-008 bus_access  in  1  one-cycle pulse per CPU bus cycle; bus_addr valid while high; read and write treated alike.
REQ-009 kbd_sel  out  1  high when bus_addr is in $C000-$C00F (combinational).
REQ-010 kbd_data  out  8  {key_strobe, latched code[6:0]}; valid every cycle.
REQ-011 key_strobe  out  1  Apple II keyboard strobe; high = unread key in latch.
REQ-012 fifo_count  out  5  number of queued, not yet latched, entries.
REQ-013 overflow  out  1  sticky: a push was dropped because the queue was full.

Function
REQ-014 SHALL register keycode[6:0] once per cycle as prev_code; change detection compares the current keycode[6:0] with prev_code.
REQ-015 Input FSM SHALL have states IDLE, DELAY, REPEAT and one repeat counter.
REQ-016 In any state, if keycode[6:0] is nonzero and differs from prev_code: push the code, clear the counter, go to DELAY.
REQ-017 In any state, if keycode[6:0]==0: go to IDLE, clear the counter, no push.
REQ-018 In DELAY, when the counter reaches REPEAT_DELAY-1: push the current code, clear the counter, go to REPEAT.
REQ-019 In REPEAT, when the counter reaches REPEAT_PERIOD-1: push the current code, clear the counter, stay in REPEAT.
REQ-020 Otherwise, in DELAY or REPEAT the counter SHALL increment by 1 per cycle; the counter SHALL be wide enough that it never wraps below its terminal count.
REQ-021 Push when full SHALL drop the code and set overflow, unless a pop occurs in the same cycle, in which case the push is accepted.
REQ-022 Pop: when key_strobe==0, the queue is non-empty and no clear is requested this cycle, the head entry SHALL be loaded into the latch and key_strobe SHALL be set on the next edge.
REQ-023 Clear: bus_access with bus_addr in $C010-$C01F in cycle N SHALL drive key_strobe low at N+1; latch bits [6:0] are retained.
REQ-024 After a clear, the earliest next pop SHALL be at cycle N+1, so strobe rises at N+2 (at least one cycle low, visible to software).
REQ-025 If a clear coincides with the cycle a pop would set the strobe, the clear SHALL win and the pop is deferred.
REQ-026 A clear while key_strobe==0 SHALL have no effect.
REQ-027 The queue SHALL be FIFO-ordered; a simultaneous push and pop with an empty queue SHALL NOT bypass (the entry is latched one cycle later).
REQ-028 fifo_count SHALL reflect the registered occupancy after each edge.
REQ-029 overflow SHALL clear only on reset.

Reset
REQ-030 On reset: key_strobe=0, latch=0 (kbd_data=8'h00), queue empty (fifo_count=0), overflow=0, FSM=IDLE, counter=0, prev_code=0.
REQ-031 Reset asserted mid-operation SHALL abort any pending repeat and discard queued entries; an unchanged nonzero keycode after reset counts as a new press (prev_code=0).

Verification (bench overrides REPEAT_DELAY=8, REPEAT_PERIOD=4, FIFO_DEPTH=4)
REQ-032 keycode 0->8'h41, held one cycle then 0 -> one push; kbd_data=8'hC1 within 3 cycles; access $C010 -> kbd_data=8'h41 next cycle; fifo_count=0.
REQ-033 keycode 8'h41 held 20 cycles, no clears -> pushes at press, +8, +12, +16, +20; latch 8'hC1, fifo_count=4, overflow=0.
REQ-034 Push 6 distinct codes 'A'..'F' without clears -> latch 'A', queue B-E, 'F' dropped, overflow=1; five clears read A,B,C,D,E in order.
REQ-035 Clear on the cycle a queued entry would load -> strobe stays low that edge and rises the following edge with the next code.
REQ-036 keycode changes 8'h41->8'h42 with no 0 between -> second push of 8'h42; repeat timing restarts from the change.
REQ-037 Reset pulse with keycode held at 8'h41 and 3 queued entries -> all outputs at reset values; one cycle after release 'A' is pushed again.
